// File: rtl/lsu_align_pkg.sv
// Shared definitions for the load/store alignment unit.
//   - funct3 encodings for RV32I loads/stores
//   - full-word strobe constant driven to the data memory
//   - two-state FSM enum (IDLE / SECOND half of a split access)
//   - helpers: legality check, access size, byte-lane mask, lane merge
package lsu_align_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // The memory is always accessed as a whole word; its sub-word paths stay idle.
  localparam logic [1:0] DM_STROBE_WORD = 2'b00;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SECOND = 1'b1
  } lsu_state_e;

  function automatic logic f3_legal(input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W, F3_BU, F3_HU: ok = 1'b1;
      default:                        ok = 1'b0;
    endcase
    return ok;
  endfunction

  // Access size in bytes, taken from funct3[1:0].
  function automatic logic [2:0] f3_nbytes(input logic [2:0] f3);
    logic [2:0] n;
    case (f3[1:0])
      2'b00:   n = 3'd1;
      2'b01:   n = 3'd2;
      default: n = 3'd4;
    endcase
    return n;
  endfunction

  // Byte-lane mask over a two-word window: bits [3:0] are lanes of the first
  // word, bits [7:4] lanes of the following word.
  function automatic logic [7:0] lane_mask(input logic [1:0] off, input logic [2:0] nbytes);
    logic [7:0] base;
    case (nbytes)
      3'd4:    base = 8'h0F;
      3'd2:    base = 8'h03;
      default: base = 8'h01;
    endcase
    return base << off;
  endfunction

  // Replace the lanes selected by mask with the corresponding bytes of new_w.
  function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  mask);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = mask[i] ? new_w[8*i +: 8] : old_w[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/lsu_load_extract.sv
// Combinational load extractor: shifts a 64-bit window right by the byte
// offset and sign- or zero-extends according to funct3.
//   i_window  : {upper word, lower word} (upper is zero for aligned loads)
//   i_off     : byte offset of the access within the lower word
//   i_funct3  : load type; illegal codes give zero
//   o_rdata   : extended load result
module lsu_load_extract
  import lsu_align_pkg::*;
(
  input  logic [63:0] i_window,
  input  logic [1:0]  i_off,
  input  logic [2:0]  i_funct3,
  output logic [31:0] o_rdata
);

  logic [63:0] w_shifted;
  logic [31:0] w_low;
  logic [31:0] w_unused_hi;

  assign w_shifted   = i_window >> {i_off, 3'b000};
  assign w_low       = w_shifted[31:0];
  assign w_unused_hi = w_shifted[63:32];

  always_comb begin
    o_rdata = 32'h0;
    case (i_funct3)
      F3_B:    o_rdata = {{24{w_low[7]}}, w_low[7:0]};
      F3_H:    o_rdata = {{16{w_low[15]}}, w_low[15:0]};
      F3_W:    o_rdata = w_low;
      F3_BU:   o_rdata = {24'h0, w_low[7:0]};
      F3_HU:   o_rdata = {16'h0, w_low[15:0]};
      default: o_rdata = 32'h0;
    endcase
  end

endmodule

// File: rtl/lsu_align.sv
// Load/store alignment unit between the MEM stage and a word-organised data
// memory. Sub-word stores use read-modify-write; accesses crossing a word
// boundary are split over two cycles with a one-cycle stall.
//   i_clk, i_rst        : clock, asynchronous active-high reset
//   i_mem_valid/i_mem_we: request present / store (1) or load (0)
//   i_funct3, i_addr    : access type and byte address
//   i_wdata             : right-justified store data
//   o_stall             : hold MEM and earlier stages this cycle
//   o_rdata             : extended load result
//   o_dm_*              : data memory word address, strobe, write data, enable
//   i_dm_rdata          : combinational memory read data for o_dm_addr
//   o_state             : debug view of the FSM state
//
// Handshake: a request is taken whenever i_mem_valid is high in IDLE. While
// o_stall is high the requester holds all request inputs stable; SECOND uses
// them without re-checking validity.
module lsu_align
  import lsu_align_pkg::*;
#(
  parameter int AW = 7
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_mem_valid,
  input  logic        i_mem_we,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_stall,
  output logic [31:0] o_rdata,
  output logic [31:0] o_dm_addr,
  output logic [1:0]  o_dm_strobe,
  output logic [31:0] o_dm_wdata,
  output logic        o_dm_wen,
  input  logic [31:0] i_dm_rdata,
  output lsu_state_e  o_state
);

  lsu_state_e    r_state;
  lsu_state_e    w_state_next;
  logic [31:0]   r_hold;

  logic [AW-1:0] w_word;
  logic [AW-1:0] w_word_next;
  logic [1:0]    w_off;
  logic          w_legal;
  logic [2:0]    w_nbytes;
  logic [3:0]    w_end;
  logic          w_split;
  logic          w_active;
  logic [7:0]    w_mask;
  logic [63:0]   w_wdata64;
  logic [63:0]   w_window;
  logic [31:0]   w_extract;
  logic          w_unused_addr;

  assign w_word        = i_addr[AW+1:2];
  assign w_word_next   = w_word + {{(AW-1){1'b0}}, 1'b1};  // wraps past the last word
  assign w_off         = i_addr[1:0];
  assign w_unused_addr = ^i_addr[31:AW+2];
  assign w_legal       = f3_legal(i_funct3);
  assign w_nbytes      = f3_nbytes(i_funct3);
  assign w_end         = {2'b00, w_off} + {1'b0, w_nbytes};
  assign w_split       = w_legal & (w_end > 4'd4);
  assign w_active      = i_mem_valid & w_legal;
  assign w_mask        = lane_mask(w_off, w_nbytes);
  // Store data placed in a two-word window: low half for the first word,
  // high half for the spill-over into the next word.
  assign w_wdata64     = {32'h0, i_wdata} << {w_off, 3'b000};
  assign w_window      = (r_state == ST_SECOND) ? {i_dm_rdata, r_hold} : {32'h0, i_dm_rdata};

  lsu_load_extract u_extract (
    .i_window (w_window),
    .i_off    (w_off),
    .i_funct3 (i_funct3),
    .o_rdata  (w_extract)
  );

  // State register
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Low word of a split load, consumed in SECOND
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_hold <= 32'h0;
    end else if (r_state == ST_IDLE && w_active && w_split && !i_mem_we) begin
      r_hold <= i_dm_rdata;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    if (r_state == ST_IDLE) begin
      if (w_active && w_split) w_state_next = ST_SECOND;
    end else begin
      w_state_next = ST_IDLE;
    end
  end

  // Output logic
  always_comb begin
    o_stall     = 1'b0;
    o_rdata     = 32'h0;
    o_dm_addr   = 32'h0;
    o_dm_strobe = DM_STROBE_WORD;
    o_dm_wdata  = i_dm_rdata;
    o_dm_wen    = 1'b0;
    o_state     = r_state;
    if (r_state == ST_IDLE) begin
      if (w_active) begin
        o_dm_addr = {{(32-AW){1'b0}}, w_word};
        o_stall   = w_split;
        if (i_mem_we) begin
          o_dm_wen   = 1'b1;
          o_dm_wdata = lane_merge(i_dm_rdata, w_wdata64[31:0], w_mask[3:0]);
        end else if (!w_split) begin
          o_rdata = w_extract;
        end
      end
    end else begin
      o_dm_addr = {{(32-AW){1'b0}}, w_word_next};
      if (i_mem_we) begin
        o_dm_wen   = 1'b1;
        o_dm_wdata = lane_merge(i_dm_rdata, w_wdata64[63:32], w_mask[7:4]);
      end else begin
        o_rdata = w_extract;
      end
    end
  end

endmodule

// File: tb/tb_lsu_align.sv
module tb_lsu_align;
  import lsu_align_pkg::*;

  localparam int AW     = 7;
  localparam int NWORDS = 1 << AW;
  localparam int NBYTES = 4 * NWORDS;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_we;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata;
  logic        stall, dm_wen;
  logic [31:0] rdata, dm_addr, dm_wdata, dm_rdata;
  logic [1:0]  dm_strobe;
  lsu_state_e  state;

  always #5 clk = ~clk;

  lsu_align #(.AW(AW)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_mem_valid (mem_valid),
    .i_mem_we    (mem_we),
    .i_funct3    (funct3),
    .i_addr      (addr),
    .i_wdata     (wdata),
    .o_stall     (stall),
    .o_rdata     (rdata),
    .o_dm_addr   (dm_addr),
    .o_dm_strobe (dm_strobe),
    .o_dm_wdata  (dm_wdata),
    .o_dm_wen    (dm_wen),
    .i_dm_rdata  (dm_rdata),
    .o_state     (state)
  );

  // ---------------- data memory (environment) ----------------
  logic [31:0] mem [NWORDS];
  logic        pl_en;
  int          pl_idx;
  logic [31:0] pl_val;

  assign dm_rdata = mem[dm_addr[AW-1:0]];

  always @(posedge clk) begin
    if (dm_wen)     mem[dm_addr[AW-1:0]] <= dm_wdata;
    else if (pl_en) mem[pl_idx] <= pl_val;
  end

  // ---------------- reference model / scoreboard ----------------
  logic [7:0]  bmem [NBYTES];
  logic [31:0] exp_q [$];
  int          n_checks = 0;
  int          n_fail   = 0;

  function automatic int nb_of(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_load(input int a, input logic [2:0] f3);
    logic [31:0] v;
    int nb;
    v  = 32'h0;
    nb = nb_of(f3);
    for (int i = 0; i < nb; i++) v[8*i +: 8] = bmem[(a + i) % NBYTES];
    if (f3 == F3_B)  v = {{24{v[7]}}, v[7:0]};
    if (f3 == F3_H)  v = {{16{v[15]}}, v[15:0]};
    return v;
  endfunction

  task automatic ref_store(input int a, input logic [2:0] f3, input logic [31:0] d);
    for (int i = 0; i < nb_of(f3); i++) bmem[(a + i) % NBYTES] = d[8*i +: 8];
  endtask

  function automatic logic [31:0] ref_word(input int w);
    return {bmem[4*w+3], bmem[4*w+2], bmem[4*w+1], bmem[4*w]};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_word(input int w, input logic [31:0] v);
    @(negedge clk);
    pl_en  = 1'b1;
    pl_idx = w;
    pl_val = v;
    for (int i = 0; i < 4; i++) bmem[4*w + i] = v[8*i +: 8];
    @(negedge clk);
    pl_en = 1'b0;
  endtask

  // One request; observes each cycle just before the committing edge.
  // A second cycle is taken only when the first reported a stall.
  task automatic drive_access(input logic we, input logic [2:0] f3,
                              input logic [31:0] a, input logic [31:0] d,
                              output logic s1, output logic s2,
                              output logic [31:0] a1, output logic [31:0] a2,
                              output logic wen1, output logic [31:0] wd1,
                              output logic wen2, output logic [31:0] wd2,
                              output logic [31:0] rd);
    @(negedge clk);
    mem_valid = 1'b1;
    mem_we    = we;
    funct3    = f3;
    addr      = a;
    wdata     = d;
    #1;
    s1 = stall; a1 = dm_addr; wen1 = dm_wen; wd1 = dm_wdata; rd = rdata;
    s2 = 1'b0;  a2 = 32'h0;   wen2 = 1'b0;   wd2 = 32'h0;
    if (s1) begin
      @(negedge clk);
      #1;
      s2 = stall; a2 = dm_addr; wen2 = dm_wen; wd2 = dm_wdata; rd = rdata;
    end
    @(negedge clk);
    mem_valid = 1'b0;
    mem_we    = 1'b0;
  endtask

  logic        s1, s2, wen1, wen2;
  logic [31:0] a1, a2, wd1, wd2, rd, ex;

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1; mem_valid = 1'b0; mem_we = 1'b0; funct3 = 3'b0;
    addr = 32'h0; wdata = 32'h0; pl_en = 1'b0; pl_idx = 0; pl_val = 32'h0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    n_checks++; if (stall !== 1'b0)      begin n_fail++; $display("FAIL reset_stall: got %0d expected 0", stall); end
    n_checks++; if (dm_wen !== 1'b0)     begin n_fail++; $display("FAIL reset_wen: got %0d expected 0", dm_wen); end
    n_checks++; if (rdata !== 32'h0)     begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    n_checks++; if (state !== ST_IDLE)   begin n_fail++; $display("FAIL reset_state: got %0d expected IDLE", state); end
    n_checks++; if (dm_addr !== 32'h0)   begin n_fail++; $display("FAIL reset_dm_addr: got %h expected 0", dm_addr); end
    n_checks++; if (dm_strobe !== 2'b00) begin n_fail++; $display("FAIL reset_strobe: got %b expected 00", dm_strobe); end
  endtask

  task automatic test_load_aligned();
    logic [2:0]  f3s [5] = '{F3_B, F3_BU, F3_HU, F3_H, F3_W};
    logic [31:0] as  [5] = '{32'h0E, 32'h0E, 32'h0C, 32'h0E, 32'h0C};
    logic [31:0] exs [5] = '{32'hFFFFFF99, 32'h00000099, 32'h0000AABB, 32'hFFFF8899, 32'h8899AABB};
    set_word(3, 32'h8899AABB);
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(exs[i]);
      drive_access(1'b0, f3s[i], as[i], 32'h0, s1, s2, a1, a2, wen1, wd1, wen2, wd2, rd);
      ex = exp_q.pop_front();
      n_checks++; if (rd !== ex)     begin n_fail++; $display("FAIL load_aligned_rdata[%0d]: got %h expected %h", i, rd, ex); end
      n_checks++; if (s1 !== 1'b0)   begin n_fail++; $display("FAIL load_aligned_stall[%0d]: got %0d expected 0", i, s1); end
      n_checks++; if (a1 !== 32'd3)  begin n_fail++; $display("FAIL load_aligned_addr[%0d]: got %h expected 3", i, a1); end
      n_checks++; if (wen1 !== 1'b0) begin n_fail++; $display("FAIL load_aligned_wen[%0d]: got %0d expected 0", i, wen1); end
    end
  endtask

  task automatic test_store_aligned();
    set_word(3, 32'h8899AABB);
    exp_q.push_back(32'h889955BB);
    drive_access(1'b1, F3_B, 32'h0D, 32'h00000055, s1, s2, a1, a2, wen1, wd1, wen2, wd2, rd);
    ref_store(32'h0D, F3_B, 32'h55);
    ex = exp_q.pop_front();
    n_checks++; if (wen1 !== 1'b1)  begin n_fail++; $display("FAIL sb_wen: got %0d expected 1", wen1); end
    n_checks++; if (a1 !== 32'd3)   begin n_fail++; $display("FAIL sb_addr: got %h expected 3", a1); end
    n_checks++; if (wd1 !== ex)     begin n_fail++; $display("FAIL sb_wdata: got %h expected %h", wd1, ex); end
    n_checks++; if (s1 !== 1'b0)    begin n_fail++; $display("FAIL sb_stall: got %0d expected 0", s1); end
    n_checks++; if (mem[3] !== ex)  begin n_fail++; $display("FAIL sb_mem3: got %h expected %h", mem[3], ex); end
  endtask

  task automatic test_load_split();
    set_word(3, 32'h8899AABB);
    set_word(4, 32'h11223344);
    exp_q.push_back(32'h33448899);
    drive_access(1'b0, F3_W, 32'h0E, 32'h0, s1, s2, a1, a2, wen1, wd1, wen2, wd2, rd);
    ex = exp_q.pop_front();
    n_checks++; if (s1 !== 1'b1)   begin n_fail++; $display("FAIL lw_split_stall1: got %0d expected 1", s1); end
    n_checks++; if (a1 !== 32'd3)  begin n_fail++; $display("FAIL lw_split_addr1: got %h expected 3", a1); end
    n_checks++; if (s2 !== 1'b0)   begin n_fail++; $display("FAIL lw_split_stall2: got %0d expected 0", s2); end
    n_checks++; if (a2 !== 32'd4)  begin n_fail++; $display("FAIL lw_split_addr2: got %h expected 4", a2); end
    n_checks++; if (rd !== ex)     begin n_fail++; $display("FAIL lw_split_rdata: got %h expected %h", rd, ex); end
  endtask

  task automatic test_store_split();
    set_word(3, 32'h8899AABB);
    set_word(4, 32'h11223344);
    exp_q.push_back(32'hFE99AABB);
    exp_q.push_back(32'h112233CA);
    drive_access(1'b1, F3_H, 32'h0F, 32'h0000CAFE, s1, s2, a1, a2, wen1, wd1, wen2, wd2, rd);
    ex = exp_q.pop_front();
    n_checks++; if (s1 !== 1'b1)   begin n_fail++; $display("FAIL sh_split_stall1: got %0d expected 1", s1); end
    n_checks++; if (wd1 !== ex)    begin n_fail++; $display("FAIL sh_split_wdata1: got %h expected %h", wd1, ex); end
    n_checks++; if (mem[3] !== ex) begin n_fail++; $display("FAIL sh_split_mem3: got %h expected %h", mem[3], ex); end
    ex = exp_q.pop_front();
    n_checks++; if (wen2 !== 1'b1) begin n_fail++; $display("FAIL sh_split_wen2: got %0d expected 1", wen2); end
    n_checks++; if (a2 !== 32'd4)  begin n_fail++; $display("FAIL sh_split_addr2: got %h expected 4", a2); end
    n_checks++; if (mem[4] !== ex) begin n_fail++; $display("FAIL sh_split_mem4: got %h expected %h", mem[4], ex); end
  endtask

  task automatic test_wrap();
    set_word(NWORDS-1, 32'hDDCCBBAA);
    set_word(0, 32'h44332211);
    exp_q.push_back(32'h000011DD);
    drive_access(1'b0, F3_H, 32'h1FF, 32'h0, s1, s2, a1, a2, wen1, wd1, wen2, wd2, rd);
    ex = exp_q.pop_front();
    n_checks++; if (a1 !== 32'd127) begin n_fail++; $display("FAIL wrap_addr1: got %h expected 7f", a1); end
    n_checks++; if (s1 !== 1'b1)    begin n_fail++; $display("FAIL wrap_stall1: got %0d expected 1", s1); end
    n_checks++; if (a2 !== 32'd0)   begin n_fail++; $display("FAIL wrap_addr2: got %h expected 0", a2); end
    n_checks++; if (rd !== ex)      begin n_fail++; $display("FAIL wrap_rdata: got %h expected %h", rd, ex); end
  endtask

  task automatic test_reset_second();
    set_word(7, 32'h01234567);
    set_word(8, 32'h89ABCDEF);
    exp_q.push_back(32'hA5A54567);
    exp_q.push_back(32'h89ABCDEF);
    @(negedge clk);
    mem_valid = 1'b1; mem_we = 1'b1; funct3 = F3_W; addr = 32'h1E; wdata = 32'hA5A5A5A5;
    #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rst2_stall1: got %0d expected 1", stall); end
    @(negedge clk);
    n_checks++; if (state !== ST_SECOND) begin n_fail++; $display("FAIL rst2_in_second: got %0d expected SECOND", state); end
    rst = 1'b1; mem_valid = 1'b0; mem_we = 1'b0;
    #1;
    n_checks++; if (state !== ST_IDLE) begin n_fail++; $display("FAIL rst2_state: got %0d expected IDLE", state); end
    n_checks++; if (stall !== 1'b0)    begin n_fail++; $display("FAIL rst2_stall: got %0d expected 0", stall); end
    n_checks++; if (dm_wen !== 1'b0)   begin n_fail++; $display("FAIL rst2_wen: got %0d expected 0", dm_wen); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    ex = exp_q.pop_front();
    n_checks++; if (mem[7] !== ex) begin n_fail++; $display("FAIL rst2_mem7: got %h expected %h", mem[7], ex); end
    ex = exp_q.pop_front();
    n_checks++; if (mem[8] !== ex) begin n_fail++; $display("FAIL rst2_mem8: got %h expected %h", mem[8], ex); end
  endtask

  task automatic test_illegal();
    set_word(3, 32'h8899AABB);
    drive_access(1'b0, 3'b011, 32'h0C, 32'h0, s1, s2, a1, a2, wen1, wd1, wen2, wd2, rd);
    n_checks++; if (rd !== 32'h0)  begin n_fail++; $display("FAIL illegal_ld_rdata: got %h expected 0", rd); end
    n_checks++; if (s1 !== 1'b0)   begin n_fail++; $display("FAIL illegal_ld_stall: got %0d expected 0", s1); end
    drive_access(1'b1, 3'b111, 32'h0F, 32'h12345678, s1, s2, a1, a2, wen1, wd1, wen2, wd2, rd);
    n_checks++; if (wen1 !== 1'b0) begin n_fail++; $display("FAIL illegal_st_wen: got %0d expected 0", wen1); end
    n_checks++; if (s1 !== 1'b0)   begin n_fail++; $display("FAIL illegal_st_stall: got %0d expected 0", s1); end
    n_checks++; if (mem[3] !== 32'h8899AABB) begin n_fail++; $display("FAIL illegal_st_mem: got %h expected 8899aabb", mem[3]); end
  endtask

  task automatic test_random();
    logic [2:0] ld_f3 [5] = '{F3_B, F3_H, F3_W, F3_BU, F3_HU};
    logic [2:0] st_f3 [3] = '{F3_B, F3_H, F3_W};
    logic [2:0] f3;
    logic       we, exp_split;
    int         a;
    logic [31:0] d;
    for (int w = 0; w < NWORDS; w++) set_word(w, $urandom());
    for (int i = 0; i < 40; i++) begin
      a  = $urandom_range(0, NBYTES-1);
      we = 1'($urandom_range(0, 1));
      d  = $urandom();
      f3 = we ? st_f3[$urandom_range(0, 2)] : ld_f3[$urandom_range(0, 4)];
      exp_split = ((a % 4) + nb_of(f3)) > 4;
      if (!we) exp_q.push_back(ref_load(a, f3));
      drive_access(we, f3, 32'(a), d, s1, s2, a1, a2, wen1, wd1, wen2, wd2, rd);
      n_checks++; if (s1 !== exp_split) begin n_fail++; $display("FAIL rand_stall[%0d]: got %0d expected %0d", i, s1, exp_split); end
      if (we) begin
        ref_store(a, f3, d);
      end else begin
        ex = exp_q.pop_front();
        n_checks++; if (rd !== ex) begin n_fail++; $display("FAIL rand_rdata[%0d]: got %h expected %h (addr %h f3 %b)", i, rd, ex, a, f3); end
      end
    end
    for (int w = 0; w < NWORDS; w++) begin
      n_checks++; if (mem[w] !== ref_word(w)) begin n_fail++; $display("FAIL rand_mem[%0d]: got %h expected %h", w, mem[w], ref_word(w)); end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_load_aligned();
    test_store_aligned();
    test_load_split();
    test_store_split();
    test_wrap();
    test_reset_second();
    test_illegal();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_align.md
# lsu_align

Load/store alignment unit between the MEM pipeline stage and the word-organised data memory. It turns RV32I byte-addressed LB/LH/LW/LBU/LHU/SB/SH/SW into whole-word memory accesses. Sub-word stores use read-modify-write with correct byte lanes. Loads are shifted and sign- or zero-extended. An access that crosses a word boundary is split into two consecutive memory cycles, and the pipeline is stalled for one cycle.

## Interface
- AW, 7, word-index width of the data memory (2^AW words)
- clk  in  1  rising-edge clock
- rst  in  1  reset; asynchronous, active-high
- mem_valid  in  1  MEM stage holds a load or store
- mem_we  in  1  1 = store, 0 = load
- funct3  in  3  000 B, 001 H, 010 W, 100 BU, 101 HU; other codes are illegal
- addr  in  32  byte address
- wdata  in  32  store data, right-justified
- stall  out  1  hold MEM and earlier stages this cycle
- rdata  out  32  extended load result; valid when mem_valid & !mem_we & !stall
- dm_addr  out  32  word index in [AW-1:0]; upper bits zero
- dm_strobe  out  2  constant 2'b00 (full-word access)
- dm_wdata  out  32  merged word to write
- dm_wen  out  1  memory write enable
- dm_rdata  in  32  combinational read data for dm_addr

## Operation
- Decode: w = addr[AW+1:2], o = addr[1:0], n = 1/2/4 bytes from funct3[1:0].
- A split access is required when o+n > 4: halfword at o=3, or word at o≠0.
- Illegal funct3: no access, dm_wen=0, rdata=0, stall=0.
- The FSM has two states, IDLE and SECOND.
- IDLE, non-split access:
  - dm_addr = w.
  - Load: rdata = extend((dm_rdata >> 8o) truncated to n bytes). Sign-extend for B/H; zero-extend for BU/HU.
  - Store: dm_wen=1. dm_wdata = dm_rdata with lanes o..o+n-1 replaced by (wdata << 8o); other lanes unchanged.
- IDLE, split access:
  - dm_addr = w, stall=1, next state SECOND.
  - Load: dm_rdata is captured into the 32-bit hold register.
  - Store: lanes o..3 are written.
- SECOND:
  - dm_addr = (w+1) mod 2^AW (wraps to 0 after the last word). stall=0, next state IDLE.
  - Load: rdata = extend(bytes o..o+n-1 of {dm_rdata, hold}).
  - Store: lanes 0..o+n-5 are written with the upper bytes of wdata.
- While stall=1 the pipeline keeps mem_valid, mem_we, funct3, addr and wdata stable. The unit does not re-check them in SECOND.
- mem_valid=0 in IDLE: dm_wen=0, stall=0, dm_addr=0, rdata=0.

## Timing
- Registers: state and hold only. All outputs are combinational from state, inputs and dm_rdata.
- Reset: state=IDLE, hold=0. stall=0 and dm_wen=0 until a valid request arrives.
- Latency:
  - Aligned access: 0 extra cycles; the write commits at the next posedge.
  - Split access: 1 stall cycle; each half commits at its own posedge.
- Reset asserted while in SECOND: returns to IDLE immediately. The second half of a split store is not written. The first half stays in memory.
- A new request is sampled only in IDLE.
- dm_strobe is never non-word, so the memory's own sub-word paths stay unused.

## Structure
- Shared package holds:
  - funct3 load/store encodings
  - the word-strobe constant 2'b00
  - the two-state FSM enum
  - a byte-lane mask helper
- One natural sub-module: lsu_load_extract. It is combinational: a 64-bit window, offset and funct3 in, extended rdata out. It is used for both the aligned and the split load paths.

## Test plan
1. Reset with mem_valid=0 -> stall=0, dm_wen=0, rdata=0, state IDLE.
2. Word 3 = 0x8899AABB:
   - LB at 0x0E -> rdata 0xFFFFFF99, stall 0.
   - LBU at 0x0E -> rdata 0x00000099.
   - LHU at 0x0C -> rdata 0x0000AABB.
3. Word 3 = 0x8899AABB, SB wdata 0x55 at 0x0D -> dm_wen=1, dm_addr=3, dm_wdata=0x889955BB.
4. Word 3 = 0x8899AABB, word 4 = 0x11223344, LW at 0x0E:
   - Cycle 1: stall=1, dm_addr=3.
   - Cycle 2: stall=0, dm_addr=4, rdata=0x33448899.
5. Same memory, SH 0xCAFE at 0x0F:
   - Cycle 1 writes word 3 = 0xFE99AABB.
   - Cycle 2 writes word 4 = 0x112233CA.
6. Wrap and reset:
   - LH at 0x1FF -> second cycle dm_addr=0.
   - Split SW with rst pulsed during SECOND -> only the first word is modified, state IDLE, stall=0.
